// File: rtl/lzss_pkg.sv
// Shared definitions for the LZSS host-side controller.
//   - Default widths for host words, symbols, codewords and the codeword counter.
//   - Codeword bit-field positions.
//   - Controller state encoding.
package lzss_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int CW_W   = 11;
  localparam int CNT_W  = 12;

  // Codeword layout: bit 10 clear = literal {0, char[7:0], 2'bxx}, set = match token.
  localparam int CW_FLAG    = 10;
  localparam int CW_CHAR_HI = 9;
  localparam int CW_CHAR_LO = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE,
    ST_HALT
  } lzss_ctrl_state_t;

  function automatic logic cw_is_match(input logic [CW_W-1:0] cw);
    return cw[CW_FLAG];
  endfunction

endpackage

// File: rtl/lzss_word_fifo.sv
// Synchronous word FIFO with an occupancy count.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   wr, wdata    push (ignored when full)
//   rd, rdata    pop (ignored when empty); rdata shows the head combinationally
//   count        current occupancy, 0..DEPTH
module lzss_word_fifo
  import lzss_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_wr, do_rd;

  assign do_wr = wr & (count != FULL);
  assign do_rd = rd & (count != '0);
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/lzss_host_ctrl.sv
// Host-side sequencer in front of the LZSS encoder core.
// Buffers host words, unpacks them MSB-byte-first into a symbol stream,
// tracks end-of-input, registers/counts the core's codewords and pulses finish.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   data, data_valid, busy      host word handshake (accepted when busy = 0)
//   drop_done                   host level: last word has been issued
//   byte_out/valid/last/ready   symbol stream to the core
//   cw_in, cw_valid, cw_last    codewords from the core (no backpressure)
//   codeword, out_valid         registered codeword output
//   enc_num                     saturating codeword count
//   finish                      one-cycle completion pulse
module lzss_host_ctrl #(
  parameter int WORD_W     = lzss_pkg::WORD_W,
  parameter int BYTE_W     = lzss_pkg::BYTE_W,
  parameter int CW_W       = lzss_pkg::CW_W,
  parameter int CNT_W      = lzss_pkg::CNT_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] data,
  input  logic              data_valid,
  input  logic              drop_done,
  output logic              busy,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              byte_last,
  input  logic              byte_ready,
  input  logic [CW_W-1:0]   cw_in,
  input  logic              cw_valid,
  input  logic              cw_last,
  output logic [CW_W-1:0]   codeword,
  output logic              out_valid,
  output logic [CNT_W-1:0]  enc_num,
  output logic              finish
);

  import lzss_pkg::*;

  localparam int BPW   = WORD_W / BYTE_W;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);
  localparam logic [FA_W:0]    BUSY_TH  = (FA_W+1)'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  lzss_ctrl_state_t state, state_next;

  logic [WORD_W-1:0] cur_word, fifo_head;
  logic [IDX_W-1:0]  idx;
  logic [FA_W:0]     fifo_count, occ_post;
  logic              wr, pop, xfer, word_end, fifo_empty, got_word, busy_next;

  assign xfer       = byte_valid & byte_ready;
  assign word_end   = xfer & (idx == IDX_LAST);
  assign fifo_empty = (fifo_count == '0);
  assign wr         = data_valid & ~busy & (state == ST_FEED);
  // Refill the unpacker when it is idle or finishing its word: no bubble between words.
  assign pop        = (~byte_valid | word_end) & ~fifo_empty;
  // Occupancy after the edge, deliberately ignoring a same-cycle pop.
  assign occ_post   = fifo_count + {{FA_W{1'b0}}, wr};

  // The current word shifts left on each transfer, so the symbol is always the top byte.
  assign byte_out   = cur_word[WORD_W-1 -: BYTE_W];
  // DRAIN is only entered with drop_done latched, so the state carries that flag.
  assign byte_last  = byte_valid & (idx == IDX_LAST) & (state == ST_DRAIN) & fifo_empty;

  lzss_word_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .wdata (data),
    .rd    (pop),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_next  = 1'b1;
    case (state)
      ST_IDLE:  state_next = ST_FEED;
      ST_FEED: begin
        if (drop_done) begin
          if (wr | ~fifo_empty | (byte_valid & ~word_end)) state_next = ST_DRAIN;
          // Everything already went out before drop_done: skip straight to codeword wait.
          else if (got_word)                               state_next = ST_FLUSH;
          else                                             state_next = ST_DONE;
        end
      end
      ST_DRAIN: if (xfer & byte_last)     state_next = ST_FLUSH;
      ST_FLUSH: if (cw_valid & cw_last)   state_next = ST_DONE;
      ST_DONE:  state_next = ST_HALT;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
    if (state_next == ST_FEED) busy_next = (occ_post >= BUSY_TH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b1;
      byte_valid <= 1'b0;
      cur_word   <= '0;
      idx        <= '0;
      got_word   <= 1'b0;
      codeword   <= '0;
      out_valid  <= 1'b0;
      enc_num    <= '0;
      finish     <= 1'b0;
    end else begin
      busy   <= busy_next;
      finish <= (state == ST_DONE);
      if (wr) got_word <= 1'b1;

      if (pop) begin
        cur_word   <= fifo_head;
        idx        <= '0;
        byte_valid <= 1'b1;
      end else if (xfer) begin
        cur_word <= cur_word << BYTE_W;
        idx      <= idx + 1'b1;
        if (word_end) byte_valid <= 1'b0;
      end

      if (state != ST_HALT) begin
        codeword  <= cw_in;
        out_valid <= cw_valid;
        if (cw_valid && enc_num != CNT_MAX) enc_num <= enc_num + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lzss_host_ctrl.sv
// Scoreboard bench for lzss_host_ctrl: drivers push expected bytes/codewords,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_lzss_host_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data = '0;
  logic        data_valid = 1'b0;
  logic        drop_done = 1'b0;
  logic        busy;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_last;
  logic        byte_ready = 1'b1;
  logic [10:0] cw_in = '0;
  logic        cw_valid = 1'b0;
  logic        cw_last = 1'b0;
  logic [10:0] codeword;
  logic        out_valid;
  logic [11:0] enc_num;
  logic        finish;

  lzss_host_ctrl dut (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .drop_done(drop_done), .busy(busy), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .cw_in(cw_in), .cw_valid(cw_valid), .cw_last(cw_last),
    .codeword(codeword), .out_valid(out_valid), .enc_num(enc_num), .finish(finish)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic last; logic [7:0] b; } byte_exp_t;
  typedef struct packed { logic [10:0] cw; logic [11:0] n; } cw_exp_t;

  byte_exp_t exp_bytes[$];
  cw_exp_t   exp_cw[$];
  int total = 0;
  int bad = 0;
  int cw_sent = 0;
  int gaps = 0;
  bit gap_mode = 0;
  bit seen_first = 0;
  bit prev_stall = 0;
  logic [7:0] prev_byte = '0;
  byte_exp_t mon_be;
  cw_exp_t   mon_ce;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(byte_valid), 32'd1);
        chk("hold_byte", 32'(byte_out), 32'(prev_byte));
      end
      if (byte_valid && byte_ready) begin
        if (exp_bytes.size() == 0) begin
          total++; bad++;
          $display("FAIL byte_extra: got %0h want no byte", byte_out);
        end else begin
          mon_be = exp_bytes.pop_front();
          chk("byte", 32'({byte_last, byte_out}), 32'({mon_be.last, mon_be.b}));
        end
        seen_first = 1;
      end else if (gap_mode && seen_first && exp_bytes.size() != 0 && !byte_valid) begin
        gaps++;
      end
      if (out_valid) begin
        if (exp_cw.size() == 0) begin
          total++; bad++;
          $display("FAIL cw_extra: got %0h want no codeword", codeword);
        end else begin
          mon_ce = exp_cw.pop_front();
          chk("codeword", 32'(codeword), 32'(mon_ce.cw));
          chk("enc_num", 32'(enc_num), 32'(mon_ce.n));
        end
      end
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
    end
  end

  task automatic apply_reset();
    reset = 1'b1; data_valid = 1'b0; drop_done = 1'b0;
    cw_valid = 1'b0; cw_last = 1'b0; data = '0; cw_in = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_bytes.delete(); exp_cw.delete();
    cw_sent = 0; gaps = 0; seen_first = 0; gap_mode = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_bvalid", 32'(byte_valid), 32'd0);
    chk("rst_blast", 32'(byte_last), 32'd0);
    chk("rst_bout", 32'(byte_out), 32'd0);
    chk("rst_cw", 32'(codeword), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_enc", 32'(enc_num), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    @(posedge clk); #1;
    chk("feed_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] mkw(input logic [31:0] base, input int k);
    return base + 32'(k) * 32'h01030507;
  endfunction

  // Host driver: offers junk with data_valid while busy (must be ignored).
  task automatic send_words(input logic [31:0] base, input int n, input bit dd_last);
    int k;
    int t;
    logic [31:0] w;
    byte_exp_t e;
    k = 0; t = 0;
    while (k < n && t < n * 20 + 50) begin
      if (!busy) begin
        w = mkw(base, k);
        data = w; data_valid = 1'b1;
        if (dd_last && k == n - 1) drop_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
          e.b = w[31 - 8 * i -: 8];
          e.last = dd_last && (k == n - 1) && (i == 3);
          exp_bytes.push_back(e);
        end
        k++;
      end else begin
        data = 32'hDEADBEEF; data_valid = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    data_valid = 1'b0;
    chk("words_sent", 32'(k), 32'(n));
  endtask

  task automatic wait_drain(input int limit);
    int t;
    t = 0;
    while (exp_bytes.size() != 0 && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_done", 32'(exp_bytes.size()), 32'd0);
  endtask

  // Core model: alternating literal/match codewords, last one flagged.
  task automatic send_cw(input int n);
    cw_exp_t e;
    for (int i = 0; i < n; i++) begin
      cw_in = (i % 2 == 1) ? 11'h5A3 : 11'h104;
      cw_valid = 1'b1;
      cw_last = (i == n - 1);
      cw_sent++;
      e.cw = cw_in; e.n = 12'(cw_sent);
      exp_cw.push_back(e);
      @(posedge clk); #1;
    end
    cw_valid = 1'b0; cw_last = 1'b0;
    @(negedge clk);
    chk("finish_early", 32'(finish), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("finish_pulse", 32'(finish), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("finish_once", 32'(finish), 32'd0);
    chk("out_quiet", 32'(out_valid), 32'd0);
    chk("enc_final", 32'(enc_num), 32'(cw_sent));
    chk("cw_left", 32'(exp_cw.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    // Single word with drop_done in the same cycle
    apply_reset();
    gap_mode = 1;
    send_words(32'h41424344, 1, 1);
    wait_drain(50);
    chk("t1_gaps", 32'(gaps), 32'd0);
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'd1);
    chk("t1_bvalid_after", 32'(byte_valid), 32'd0);
    @(posedge clk); #1;
    send_cw(1);

    // Max-rate host, 170 words, then 318 codewords
    apply_reset();
    gap_mode = 1;
    send_words(32'h10203040, 170, 1);
    wait_drain(2000);
    chk("t2_gaps", 32'(gaps), 32'd0);
    gap_mode = 0;
    send_cw(318);
    chk("t2_enc318", 32'(enc_num), 32'd318);

    // Core stalls 10 cycles mid-word
    apply_reset();
    fork
      send_words(32'hA0B1C2D3, 3, 1);
      begin
        repeat (4) @(posedge clk);
        #1 byte_ready = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t3_busy_stall", 32'(busy), 32'd1);
        @(posedge clk);
        #1 byte_ready = 1'b1;
      end
    join
    wait_drain(200);
    send_cw(2);

    // Empty stream
    apply_reset();
    drop_done = 1'b1;
    @(negedge clk);
    chk("t5_fin_c0", 32'(finish), 32'd0);
    @(posedge clk); #1;
    drop_done = 1'b0;
    @(negedge clk);
    chk("t5_fin_c1", 32'(finish), 32'd0);
    chk("t5_bvalid", 32'(byte_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_fin_c2", 32'(finish), 32'd1);
    chk("t5_enc", 32'(enc_num), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_fin_c3", 32'(finish), 32'd0);
    chk("t5_bvalid_end", 32'(byte_valid), 32'd0);

    // Reset while draining with a word buffered, then a fresh stream
    apply_reset();
    byte_ready = 1'b0;
    send_words(32'h55667788, 2, 1);
    @(negedge clk);
    chk("t6_pre_valid", 32'(byte_valid), 32'd1);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    apply_reset();
    byte_ready = 1'b1;
    send_words(32'hC0FFEE01, 2, 1);
    wait_drain(100);
    send_cw(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
